// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI address-channel arbiter.
// Tag values are chosen so that tag 0 is never issued.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

package axi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int AXI_ADDR_BITS = `AXI_ADDR_BITS;
  localparam int TAG_M0        = 1;
  localparam int TAG_M1        = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, and a tie goes to the
// master that was not granted last.
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

  always_comb begin
    sel = ~last;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~last;
    endcase
  end

endmodule

// File: rtl/axi_addr_arbiter.sv
// Round-robin merge of two AXI address channels into one tagged stream.
// The grant is held from the first valid cycle until the handshake completes.
module axi_addr_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_BITS,
  parameter int ID_W   = 4,
  parameter int TAG_W  = 4,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     M0_Addr,
  input  logic [ID_W-1:0]       M0_ID,
  input  logic [LEN_W-1:0]      M0_Len,
  input  logic [2:0]            M0_Size,
  input  logic [1:0]            M0_Burst,
  input  logic                  M0_Valid,
  output logic                  M0_Ready,
  input  logic [ADDR_W-1:0]     M1_Addr,
  input  logic [ID_W-1:0]       M1_ID,
  input  logic [LEN_W-1:0]      M1_Len,
  input  logic [2:0]            M1_Size,
  input  logic [1:0]            M1_Burst,
  input  logic                  M1_Valid,
  output logic                  M1_Ready,
  output logic [ADDR_W-1:0]     O_Addr,
  output logic [TAG_W+ID_W-1:0] O_IDS,
  output logic [LEN_W-1:0]      O_Len,
  output logic [2:0]            O_Size,
  output logic [1:0]            O_Burst,
  output logic                  O_Valid,
  input  logic                  O_Ready
);

  localparam logic [TAG_W-1:0] TAG0 = TAG_W'(TAG_M0);
  localparam logic [TAG_W-1:0] TAG1 = TAG_W'(TAG_M1);

  arb_state_e state_reg;
  logic       grant_reg;
  logic       last_grant_reg;
  logic       sel;
  logic       cur;
  logic       cur_valid;

  rr_arb2 u_rr_arb2 (
    .req  ({M1_Valid, M0_Valid}),
    .last (last_grant_reg),
    .sel  (sel)
  );

  // While locked the other master is ignored, so the registered grant drives the mux.
  assign cur       = (state_reg == LOCK) ? grant_reg : sel;
  assign cur_valid = cur ? M1_Valid : M0_Valid;

  assign O_Addr  = cur ? M1_Addr  : M0_Addr;
  assign O_IDS   = cur ? {TAG1, M1_ID} : {TAG0, M0_ID};
  assign O_Len   = cur ? M1_Len   : M0_Len;
  assign O_Size  = cur ? M1_Size  : M0_Size;
  assign O_Burst = cur ? M1_Burst : M0_Burst;

  // Gating with rst makes the handshake signals drop immediately on reset.
  assign O_Valid  = cur_valid & ~rst;
  assign M0_Ready = ~cur & O_Ready & ~rst;
  assign M1_Ready =  cur & O_Ready & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cur_valid) begin
            if (O_Ready) begin
              last_grant_reg <= sel;
            end else begin
              state_reg <= LOCK;
              grant_reg <= sel;
            end
          end
        end
        LOCK: begin
          // A master withdrawing Valid releases the lock without counting as a transfer.
          if (!cur_valid) begin
            state_reg <= IDLE;
          end else if (O_Ready) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// Directed vector bench for axi_addr_arbiter with hand-written reset sequences.
module tb_axi_addr_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr, m1_addr;
  logic [3:0]  m0_id, m1_id, m0_len, m1_len;
  logic [2:0]  m0_size, m1_size;
  logic [1:0]  m0_burst, m1_burst;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] o_addr;
  logic [7:0]  o_ids;
  logic [3:0]  o_len;
  logic [2:0]  o_size;
  logic [1:0]  o_burst;
  logic        o_valid, o_ready;

  int tests_run = 0;
  int tests_failed = 0;

  axi_addr_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .M0_Addr  (m0_addr),
    .M0_ID    (m0_id),
    .M0_Len   (m0_len),
    .M0_Size  (m0_size),
    .M0_Burst (m0_burst),
    .M0_Valid (m0_valid),
    .M0_Ready (m0_ready),
    .M1_Addr  (m1_addr),
    .M1_ID    (m1_id),
    .M1_Len   (m1_len),
    .M1_Size  (m1_size),
    .M1_Burst (m1_burst),
    .M1_Valid (m1_valid),
    .M1_Ready (m1_ready),
    .O_Addr   (o_addr),
    .O_IDS    (o_ids),
    .O_Len    (o_len),
    .O_Size   (o_size),
    .O_Burst  (o_burst),
    .O_Valid  (o_valid),
    .O_Ready  (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       m0v;
    logic       m1v;
    logic       rdy;
    logic       ev;
    logic       em0r;
    logic       em1r;
    logic       chk_ids;
    logic [7:0] eids;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_payload(input logic [3:0] tag);
    if (tag == 4'd1) begin
      check("addr_m0", o_addr, 32'h1000_0000);
      check("len_m0", {28'd0, o_len}, 32'h3);
      check("size_m0", {29'd0, o_size}, 32'd2);
      check("burst_m0", {30'd0, o_burst}, 32'd1);
    end else begin
      check("addr_m1", o_addr, 32'h0001_0040);
      check("len_m1", {28'd0, o_len}, 32'hF);
      check("size_m1", {29'd0, o_size}, 32'd1);
      check("burst_m1", {30'd0, o_burst}, 32'd2);
    end
  endtask

  initial begin
    m0_addr = 32'h1000_0000; m0_id = 4'hA; m0_len = 4'h3; m0_size = 3'd2; m0_burst = 2'd1;
    m1_addr = 32'h0001_0040; m1_id = 4'h3; m1_len = 4'hF; m1_size = 3'd1; m1_burst = 2'd2;

    // m0v m1v rdy | ev m0r m1r chk ids
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A}; // M0 wins first after reset
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23}; // single M1
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A}; // contention alternates
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1A}; // M0 stalls -> lock
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1A}; // M1 rises, ignored
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1A};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A}; // M0 completes
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23}; // then M1
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // idle, nobody valid
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A}; // last_grant -> M0
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23}; // M1 locks
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h23}; // M1 drops valid in lock
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23}; // last_grant still M0
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A};

    // Reset holds the handshake outputs low even with a valid request
    rst = 1'b1; m0_valid = 1'b1; m1_valid = 1'b0; o_ready = 1'b1;
    #1;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    $display("[TB] reset: o_valid=%0b m0_ready=%0b", o_valid, m0_ready);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      m0_valid = vecs[i].m0v;
      m1_valid = vecs[i].m1v;
      o_ready  = vecs[i].rdy;
      #2;
      check($sformatf("v%0d_o_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_m0_ready", i), {31'd0, m0_ready}, {31'd0, vecs[i].em0r});
      check($sformatf("v%0d_m1_ready", i), {31'd0, m1_ready}, {31'd0, vecs[i].em1r});
      if (vecs[i].chk_ids)
        check($sformatf("v%0d_o_ids", i), {24'd0, o_ids}, {24'd0, vecs[i].eids});
      if (vecs[i].ev)
        check_payload(vecs[i].eids[7:4]);
      $display("[TB] vec %0d: m0v=%0b m1v=%0b rdy=%0b -> o_valid=%0b ids=%h m0r=%0b m1r=%0b",
               i, m0_valid, m1_valid, o_ready, o_valid, o_ids, m0_ready, m1_ready);
      @(posedge clk); #1;
    end

    // Reset while locked on M1: outputs drop before any clock edge, M0 regains priority
    m0_valid = 1'b1; m1_valid = 1'b1; o_ready = 1'b0;
    #2;
    check("lock_pre_ids", {24'd0, o_ids}, 32'h23);
    @(posedge clk); #2;
    o_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("async_rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    $display("[TB] async reset in lock: o_valid=%0b m1_ready=%0b", o_valid, m1_ready);
    @(posedge clk); #2;
    rst = 1'b0;
    #2;
    check("post_rst_ids", {24'd0, o_ids}, 32'h1A);
    check("post_rst_m0_ready", {31'd0, m0_ready}, 32'd1);
    check("post_rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    $display("[TB] after reset release: ids=%h m0r=%0b m1r=%0b", o_ids, m0_ready, m1_ready);
    @(posedge clk); #2;
    check("post_rst_next_ids", {24'd0, o_ids}, 32'h23);
    $display("[TB] following transfer: ids=%h", o_ids);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
